// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/drain/dump/halt control with load-use and branch hazard handling
module pipeline_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        end_d,
  input  logic        mem_read_e,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rt_e,
  input  logic        branch_taken_d,
  input  logic        jump_d,
  input  logic        dump_ready,
  output logic        pc_en,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        dump_valid,
  output logic [8:0]  dump_addr,
  output logic        halted,
  output logic [31:0] cycle_count
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] DUMP  = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [8:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] cycle_q, cycle_d;
  logic        load_use, run, drain, redirect;
  assign load_use = mem_read_e && (rt_e != 5'd0) && (rt_e == rs_d || rt_e == rt_d);
  assign run      = !rst && state_q == RUN;
  assign drain    = !rst && state_q == DRAIN;
  assign redirect = branch_taken_d || jump_d || end_d;
  assign pc_en    = run && !load_use;
  assign stall_f  = run && load_use;
  assign stall_d  = run && load_use;
  assign flush_e  = run && load_use;
  assign flush_d  = (run && !load_use && redirect) || drain;
  assign dump_valid  = valid_q;
  assign dump_addr   = valid_q ? addr_q : 9'd0;
  assign halted      = halted_q;
  assign cycle_count = cycle_q;
  // next-state: sequencing, drain countdown, dump address walk and saturating cycle count
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cycle_d  = cycle_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cycle_d = '0;
      end
      RUN: begin
        cycle_d = cycle_q + {31'd0, ~&cycle_q};
        if (end_d && !load_use) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end
      end
      DRAIN: begin
        cycle_d = cycle_q + {31'd0, ~&cycle_q};
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d = DUMP;
          addr_d  = 9'd0;
          valid_d = 1'b1;
        end
      end
      DUMP: if (dump_ready) begin
        if (addr_q == 9'd511) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else addr_d = addr_q + 9'd1;
      end
      default: ;
    endcase
  end
  // state registers with immediate asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      drain_q  <= 2'd0;
      addr_q   <= 9'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cycle_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cycle_q  <= cycle_d;
    end
  end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: randomized bench against a behavioural sequencer model
module tb_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 0, end_d = 0, mem_read_e = 0, branch_taken_d = 0, jump_d = 0, dump_ready = 0;
  logic [4:0] rs_d = 0, rt_d = 0, rt_e = 0;
  logic pc_en, stall_f, stall_d, flush_d, flush_e, dump_valid, halted;
  logic [8:0] dump_addr;
  logic [31:0] cycle_count;
  int checks = 0, passes = 0;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DUMP = 3, P_HALT = 4;
  int m_phase = P_IDLE;
  int m_drain_left = 0;
  int m_addr = 0;
  logic [31:0] m_cyc = 0;

  pipeline_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .end_d(end_d), .mem_read_e(mem_read_e),
    .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e), .branch_taken_d(branch_taken_d),
    .jump_d(jump_d), .dump_ready(dump_ready), .pc_en(pc_en), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit hazard();
    return mem_read_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE;
      m_addr <= 0;
      m_drain_left <= 0;
      m_cyc <= 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase <= P_RUN;
          m_cyc <= 0;
        end
        P_RUN: begin
          m_cyc <= (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
          if (end_d && !hazard()) begin
            m_phase <= P_DRAIN;
            m_drain_left <= 4;
          end
        end
        P_DRAIN: begin
          m_cyc <= (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
          m_drain_left <= m_drain_left - 1;
          if (m_drain_left == 1) begin
            m_phase <= P_DUMP;
            m_addr <= 0;
          end
        end
        P_DUMP: if (dump_ready) begin
          if (m_addr == 511) m_phase <= P_HALT;
          else m_addr <= m_addr + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic bit r = (m_phase == P_RUN);
      automatic bit lu = hazard();
      automatic bit e_fd = (r && !lu && (branch_taken_d || jump_d || end_d)) || m_phase == P_DRAIN;
      chk("hazard_outputs", {pc_en, stall_f, stall_d, flush_d, flush_e},
          {r && !lu, r && lu, r && lu, e_fd, r && lu});
      chk("dump_valid", dump_valid, m_phase == P_DUMP);
      chk("dump_addr", dump_addr, m_phase == P_DUMP ? m_addr : 0);
      chk("halted", halted, m_phase == P_HALT);
      chk("cycle_count", cycle_count, m_cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 0; end_d = 0; mem_read_e = 0; branch_taken_d = 0; jump_d = 0;
    rs_d = 0; rt_d = 0; rt_e = 0;
  endtask

  task automatic rand_run();
    mem_read_e = 1'($urandom); branch_taken_d = 1'($urandom); jump_d = 1'($urandom);
    start = 1'($urandom); end_d = 0;
    rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_regs", {dump_valid, halted, cycle_count}, 34'd0);
    chk("reset_hazard", {pc_en, stall_f, stall_d, flush_d, flush_e}, 5'b0);
    start = 1;
    step();
    start = 0;
    repeat (10) step();
    @(negedge clk);
    chk("ten_cycles", cycle_count, 32'd10);
    mem_read_e = 1; rt_e = 8; rs_d = 8;
    @(negedge clk);
    chk("loaduse_stall", {pc_en, stall_f, stall_d, flush_e}, 4'b0111);
    rt_e = 0;
    #1 chk("loaduse_rt0", {pc_en, stall_f, stall_d, flush_e}, 4'b1000);
    step();
    mem_read_e = 1; rt_e = 8; rs_d = 8; branch_taken_d = 1; end_d = 1;
    @(negedge clk);
    chk("stall_priority", {pc_en, stall_f, flush_d, flush_e}, 4'b0101);
    step();
    clear_in();
    @(negedge clk);
    chk("still_run", pc_en, 1);
    repeat (200) begin
      step();
      rand_run();
    end
    step();
    clear_in();
    end_d = 1;
    @(negedge clk);
    chk("end_flush", flush_d, 1);
    step();
    end_d = 0;
    repeat (4) begin
      @(negedge clk);
      chk("drain_pc_en", {pc_en, flush_d}, 2'b01);
      step();
    end
    @(negedge clk);
    chk("dump_entry", {dump_valid, dump_addr}, {1'b1, 9'd0});
    dump_ready = 1;
    step();
    @(negedge clk);
    chk("dump_hs1", dump_addr, 1);
    dump_ready = 0;
    step();
    @(negedge clk);
    chk("dump_hold", dump_addr, 1);
    dump_ready = 1;
    step();
    @(negedge clk);
    chk("dump_hs2", dump_addr, 2);
    for (int i = 0; i < 2000 && m_addr != 200; i++) begin
      dump_ready = 1'($urandom);
      step();
    end
    dump_ready = 0;
    @(negedge clk);
    chk("dump_at_200", dump_addr, 200);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_regs", {dump_valid, halted, dump_addr, cycle_count}, 43'd0);
    chk("async_rst_hazard", {pc_en, stall_f, stall_d, flush_d, flush_e}, 5'b0);
    step();
    rst = 0;
    start = 1;
    step();
    start = 0;
    repeat (3) step();
    @(negedge clk);
    chk("restart_count", cycle_count, 3);
    repeat (20) begin
      step();
      rand_run();
    end
    step();
    clear_in();
    end_d = 1;
    step();
    end_d = 0;
    for (int i = 0; i < 3000 && m_phase != P_HALT; i++) begin
      dump_ready = ($urandom % 4) != 0;
      step();
    end
    dump_ready = 0;
    @(negedge clk);
    chk("halt_reached", {halted, dump_valid}, 2'b10);
    start = 1;
    step();
    start = 0;
    step();
    @(negedge clk);
    chk("halt_sticky", {halted, pc_en}, 2'b10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
